// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FFT constants and the complex coefficient type
// Purpose: size constants for the 128-point FFT twiddle path, the Q1.15
//          coefficient struct and the unity constant of the cosine table.
// Ports:   none (package).
package fft_pkg;

    localparam int N_LOG2 = 7;
    localparam int N      = 1 << N_LOG2;
    localparam int IDX_W  = N_LOG2 - 1;
    localparam int DATA_W = 16;
    localparam int QT     = N / 4;
    localparam int ADDR_W = IDX_W;
    localparam int Q_ONE  = 32767;

    typedef struct packed {
        logic signed [DATA_W-1:0] re;
        logic signed [DATA_W-1:0] im;
    } coef_t;

endpackage

// File: rtl/twiddle_qrom.sv
// rtl/twiddle_qrom.sv - dual-read-port synchronous quarter-wave cosine ROM
// Purpose: Q[a] = round(32767 * cos(2*pi*a/128)), a = 0..32, read on two
//          independent ports with a registered output.
// Ports:   clk, i_en (read/advance enable), i_addr_a/i_addr_b (table
//          addresses), o_data_a/o_data_b (registered table values).
module twiddle_qrom
    import fft_pkg::*;
(
    input  logic              clk,
    input  logic              i_en,
    input  logic [ADDR_W-1:0] i_addr_a,
    input  logic [ADDR_W-1:0] i_addr_b,
    output logic [DATA_W-1:0] o_data_a,
    output logic [DATA_W-1:0] o_data_b
);

    logic [DATA_W-1:0] r_data_a;
    logic [DATA_W-1:0] r_data_b;

    // Round-to-nearest values; addresses above QT never occur and read as 0.
    function automatic logic [DATA_W-1:0] q_value(input logic [ADDR_W-1:0] a);
        case (a)
            6'd0:  q_value = DATA_W'(Q_ONE);
            6'd1:  q_value = 16'd32728;
            6'd2:  q_value = 16'd32609;
            6'd3:  q_value = 16'd32412;
            6'd4:  q_value = 16'd32137;
            6'd5:  q_value = 16'd31785;
            6'd6:  q_value = 16'd31356;
            6'd7:  q_value = 16'd30852;
            6'd8:  q_value = 16'd30273;
            6'd9:  q_value = 16'd29621;
            6'd10: q_value = 16'd28898;
            6'd11: q_value = 16'd28105;
            6'd12: q_value = 16'd27245;
            6'd13: q_value = 16'd26319;
            6'd14: q_value = 16'd25329;
            6'd15: q_value = 16'd24279;
            6'd16: q_value = 16'd23170;
            6'd17: q_value = 16'd22005;
            6'd18: q_value = 16'd20787;
            6'd19: q_value = 16'd19519;
            6'd20: q_value = 16'd18204;
            6'd21: q_value = 16'd16846;
            6'd22: q_value = 16'd15446;
            6'd23: q_value = 16'd14010;
            6'd24: q_value = 16'd12539;
            6'd25: q_value = 16'd11039;
            6'd26: q_value = 16'd9512;
            6'd27: q_value = 16'd7962;
            6'd28: q_value = 16'd6393;
            6'd29: q_value = 16'd4808;
            6'd30: q_value = 16'd3212;
            6'd31: q_value = 16'd1608;
            default: q_value = '0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (i_en) begin
            r_data_a <= q_value(i_addr_a);
            r_data_b <= q_value(i_addr_b);
        end
    end

    assign o_data_a = r_data_a;
    assign o_data_b = r_data_b;

endmodule

// File: rtl/twiddle_lookup.sv
// rtl/twiddle_lookup.sv - twiddle index to Q1.15 complex coefficient pipeline
// Purpose: maps k = 0..63 to W_N^k = cos(2*pi*k/N) - j*sin(2*pi*k/N) using a
//          quarter-wave table and symmetry; 2-stage valid/ready pipeline.
// Ports:   clk, rst (sync, active-high); in_valid/in_ready/in_idx/in_last
//          index stream; out_valid/out_ready/out_re/out_im/out_last
//          coefficient stream.
module twiddle_lookup
    import fft_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [IDX_W-1:0]         in_idx,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_re,
    output logic signed [DATA_W-1:0] out_im,
    output logic                     out_last
);

    localparam logic [ADDR_W-1:0] L_QT = QT[ADDR_W-1:0];

    logic              w_en;
    logic [ADDR_W-1:0] w_cos_addr;
    logic [ADDR_W-1:0] w_sin_addr;
    logic              w_cos_neg;
    logic [DATA_W-1:0] w_cos_q;
    logic [DATA_W-1:0] w_sin_q;

    logic              r_s1_valid;
    logic              r_s1_neg;
    logic              r_s1_last;
    logic              r_s2_valid;
    coef_t             r_coef;
    logic              r_out_last;

    // Whole pipeline advances together; only a full, stalled stage 2 blocks it.
    assign w_en     = !r_s2_valid || out_ready;
    assign in_ready = w_en;

    always_comb begin
        w_cos_addr = in_idx;
        w_sin_addr = L_QT - in_idx;
        w_cos_neg  = 1'b0;
        if (in_idx > L_QT) begin
            // 2*QT - k: 2*QT equals 2^ADDR_W, so plain negation wraps to it.
            w_cos_addr = ADDR_W'(0) - in_idx;
            w_sin_addr = in_idx - L_QT;
            w_cos_neg  = 1'b1;
        end
    end

    twiddle_qrom u_qrom (
        .clk      (clk),
        .i_en     (w_en),
        .i_addr_a (w_cos_addr),
        .i_addr_b (w_sin_addr),
        .o_data_a (w_cos_q),
        .o_data_b (w_sin_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_neg   <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s2_valid <= 1'b0;
            r_coef     <= '0;
            r_out_last <= 1'b0;
        end else if (w_en) begin
            r_s1_valid <= in_valid;
            r_s1_neg   <= w_cos_neg;
            r_s1_last  <= in_last;
            r_s2_valid <= r_s1_valid;
            // Output data only changes on a real coefficient, so bubbles and
            // post-reset cycles never expose stale ROM contents.
            if (r_s1_valid) begin
                r_coef.re  <= r_s1_neg ? -$signed(w_cos_q) : $signed(w_cos_q);
                r_coef.im  <= -$signed(w_sin_q);
                r_out_last <= r_s1_last;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign out_re    = r_coef.re;
    assign out_im    = r_coef.im;
    assign out_last  = r_out_last;

endmodule

// File: tb/tb_twiddle_lookup.sv
// tb/tb_twiddle_lookup.sv - self-checking bench for twiddle_lookup
module tb_twiddle_lookup;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [5:0]         in_idx;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] out_re;
    logic signed [15:0] out_im;
    logic               out_last;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int k;
        bit last;
    } exp_t;

    exp_t exq[$];
    int   obs_re[$];
    int   obs_im[$];
    int   obs_cyc[$];

    twiddle_lookup dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_idx    (in_idx),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int rnd(input real x);
        if (x >= 0.0) return $rtoi(x + 0.5);
        return -$rtoi(-x + 0.5);
    endfunction

    function automatic int model_re(input int k);
        return rnd(32767.0 * $cos(2.0 * 3.14159265358979 * k / 128.0));
    endfunction

    function automatic int model_im(input int k);
        return -rnd(32767.0 * $sin(2.0 * 3.14159265358979 * k / 128.0));
    endfunction

    // Scoreboard: push at input handshake, pop at output handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                checks++;
                if (exq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output re=%0d im=%0d", out_re, out_im);
                end else begin
                    exp_t e;
                    int dr, di;
                    e  = exq.pop_front();
                    dr = int'(out_re) - model_re(e.k);
                    di = int'(out_im) - model_im(e.k);
                    if (dr > 1 || dr < -1 || di > 1 || di < -1 || out_last !== e.last) begin
                        errors++;
                        $display("FAIL scoreboard k=%0d got (%0d,%0d,last=%0b) want (%0d,%0d,last=%0b)",
                                 e.k, out_re, out_im, out_last, model_re(e.k), model_im(e.k), e.last);
                    end
                    obs_re.push_back(int'(out_re));
                    obs_im.push_back(int'(out_im));
                    obs_cyc.push_back(cyc);
                end
            end
            if (in_valid && in_ready) begin
                exp_t n;
                n.k    = int'(in_idx);
                n.last = in_last;
                exq.push_back(n);
            end
        end
    end

    task automatic clear_obs();
        obs_re.delete();
        obs_im.delete();
        obs_cyc.delete();
    endtask

    task automatic send(input int k, input bit last);
        bit acc;
        int kv;
        acc      = 1'b0;
        kv       = k;
        in_valid = 1'b1;
        in_idx   = kv[5:0];
        in_last  = last;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL send_timeout k=%0d got not-accepted want accepted", k);
        end
    endtask

    task automatic wait_obs(input int n);
        for (int i = 0; i < 500 && obs_re.size() < n; i++) @(posedge clk);
        #1;
        checks++;
        if (obs_re.size() != n) begin
            errors++;
            $display("FAIL output_count got %0d want %0d", obs_re.size(), n);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_idx    = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got valid=%0b last=%0b want 0 0", out_valid, out_last);
        end
        checks++;
        if (out_re !== 16'sd0 || out_im !== 16'sd0) begin
            errors++;
            $display("FAIL reset_data got (%0d,%0d) want (0,0)", out_re, out_im);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %0b want 1", in_ready);
        end
    endtask

    task automatic test_latency();
        out_ready = 1'b1;
        idle(4);
        clear_obs();
        send(1, 1'b0);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early got out_valid=%0b want 0", out_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_re !== 16'sd32728 || out_im !== -16'sd1608) begin
            errors++;
            $display("FAIL latency_k1 got valid=%0b (%0d,%0d) want 1 (32728,-1608)",
                     out_valid, out_re, out_im);
        end
        idle(3);
    endtask

    task automatic test_directed();
        int ks[7]  = '{0, 16, 32, 48, 63, 1, 31};
        int ere[7] = '{32767, 23170, 0, -23170, -32728, 32728, 1608};
        int eim[7] = '{0, -23170, -32767, -23170, -1608, -1608, -32728};
        out_ready = 1'b1;
        clear_obs();
        for (int i = 0; i < 7; i++) send(ks[i], 1'b0);
        in_valid = 1'b0;
        wait_obs(7);
        for (int i = 0; i < 7 && i < obs_re.size(); i++) begin
            checks++;
            if (obs_re[i] != ere[i] || obs_im[i] != eim[i]) begin
                errors++;
                $display("FAIL directed k=%0d got (%0d,%0d) want (%0d,%0d)",
                         ks[i], obs_re[i], obs_im[i], ere[i], eim[i]);
            end
        end
        idle(2);
    endtask

    task automatic test_sweep();
        out_ready = 1'b1;
        clear_obs();
        for (int k = 0; k < 64; k++) send(k, k == 63);
        in_valid = 1'b0;
        in_last  = 1'b0;
        wait_obs(64);
        if (obs_cyc.size() == 64) begin
            checks++;
            if (obs_cyc[63] - obs_cyc[0] != 63) begin
                errors++;
                $display("FAIL sweep_back_to_back got span %0d want 63", obs_cyc[63] - obs_cyc[0]);
            end
        end
        idle(2);
    endtask

    task automatic test_backpressure();
        int nxt;
        int re0, im0;
        nxt = 0;
        clear_obs();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_last   = 1'b0;
        for (int c = 0; c < 8; c++) begin
            in_idx = nxt[5:0];
            @(negedge clk);
            if (in_ready) nxt++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (nxt != 2 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_accept got accepted=%0d in_ready=%0b want 2 0", nxt, in_ready);
        end
        re0 = int'(out_re);
        im0 = int'(out_im);
        checks++;
        if (out_valid !== 1'b1 || re0 != 32767 || im0 != 0) begin
            errors++;
            $display("FAIL bp_head got valid=%0b (%0d,%0d) want 1 (32767,0)", out_valid, re0, im0);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || int'(out_re) != re0 || int'(out_im) != im0) begin
            errors++;
            $display("FAIL bp_stable got valid=%0b (%0d,%0d) want 1 (%0d,%0d)",
                     out_valid, out_re, out_im, re0, im0);
        end
        for (int c = 0; c < 300 && nxt < 6; c++) begin
            out_ready = 1'($urandom_range(0, 1));
            in_valid  = 1'b1;
            in_idx    = nxt[5:0];
            @(negedge clk);
            if (in_ready) nxt++;
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_obs(6);
        checks++;
        if (exq.size() != 0) begin
            errors++;
            $display("FAIL bp_pending got %0d want 0", exq.size());
        end
        idle(2);
    endtask

    task automatic test_reset_midstream();
        idle(2);
        clear_obs();
        out_ready = 1'b0;
        send(10, 1'b0);
        send(40, 1'b1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        rst      = 1'b1;
        exq.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_re !== 16'sd0 || out_im !== 16'sd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset got valid=%0b (%0d,%0d) in_ready=%0b want 0 (0,0) 1",
                     out_valid, out_re, out_im, in_ready);
        end
        out_ready = 1'b1;
        idle(6);
        checks++;
        if (obs_re.size() != 0) begin
            errors++;
            $display("FAIL midreset_stale got %0d outputs want 0", obs_re.size());
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_directed();
        test_sweep();
        test_backpressure();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
